// File: rtl/spmd_tb_reset_sequencer.sv
// spmd_tb_reset_sequencer
//   Reset, run-control and completion sequencer for multi-pod SPMD manycore
//   benches. Holds every channel in reset until all tag programming is done.
//   It then waits reset_depth_p settle cycles and releases the channels
//   stagger_p cycles apart. It runs the global cycle counter and gathers the
//   per-channel finish pulses into all_done_o.
//
//   Optional build macro: SPMD_TB_WATCHDOG_EN
//     defined   -> watchdog moves RUN to TIMEOUT once the counter reaches
//                  timeout_cycles_p, and prints a message once.
//     undefined -> no watchdog, timeout_o tied low, TIMEOUT unreachable.
//
// Ports
//   clk_i         bench core clock
//   reset_n_i     asynchronous active-low reset
//   tag_done_i    per-channel tag-programming done (level)
//   finish_v_i    per-channel finish (single-cycle pulse)
//   reset_o       per-channel downstream reset, active-high
//   global_ctr_o  cycles since channel 0 was released (saturating)
//   finished_o    sticky per-channel finish flags
//   all_done_o    all channels have finished (sticky)
//   timeout_o     watchdog expired (sticky)
//   state_o       FSM state: WAIT_TAG=0 SETTLE=1 RELEASE=2 RUN=3 DONE=4 TIMEOUT=5
module spmd_tb_reset_sequencer #(
  parameter int unsigned num_channels_p   = 1,
  parameter int unsigned reset_depth_p    = 3,
  parameter int unsigned stagger_p        = 0,
  parameter int unsigned ctr_width_p      = 32,
  parameter int unsigned timeout_cycles_p = 1000000
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [num_channels_p-1:0] tag_done_i,
  input  logic [num_channels_p-1:0] finish_v_i,
  output logic [num_channels_p-1:0] reset_o,
  output logic [ctr_width_p-1:0]    global_ctr_o,
  output logic [num_channels_p-1:0] finished_o,
  output logic                      all_done_o,
  output logic                      timeout_o,
  output logic [2:0]                state_o
);

  typedef enum logic [2:0] {
    WAIT_TAG = 3'd0,
    SETTLE   = 3'd1,
    RELEASE  = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4,
    TIMEOUT  = 3'd5
  } state_e;

  // Last settle count and last release offset, both relative to state entry.
  localparam logic [31:0] settle_last_lp  = 32'(reset_depth_p - 1);
  localparam logic [31:0] release_last_lp = 32'((num_channels_p - 1) * stagger_p);

  state_e                    state_q, state_d;
  logic [31:0]               settle_cnt_q, settle_cnt_d;
  logic [31:0]               rel_cnt_q, rel_cnt_d;
  logic [num_channels_p-1:0] reset_d;
  logic [num_channels_p-1:0] finished_d;
  logic                      all_done_d;
  logic [ctr_width_p-1:0]    ctr_d;
  logic [ctr_width_p-1:0]    ctr_inc;
  logic                      all_tags;

`ifdef SPMD_TB_WATCHDOG_EN
  localparam logic [ctr_width_p-1:0] timeout_lim_lp = ctr_width_p'(timeout_cycles_p);
  logic timeout_q, timeout_d;
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign state_o  = state_q;
  assign all_tags = &tag_done_i;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    rel_cnt_d    = rel_cnt_q;
    reset_d      = reset_o;
    finished_d   = finished_o;
    all_done_d   = all_done_o;
    ctr_d        = global_ctr_o;
`ifdef SPMD_TB_WATCHDOG_EN
    timeout_d    = timeout_q;
`endif

    ctr_inc = (global_ctr_o == '1) ? global_ctr_o : global_ctr_o + ctr_width_p'(1);

    // The counter runs once channel 0 is out of reset; it stops moving as
    // soon as the FSM leaves RELEASE/RUN, so it freezes in DONE/TIMEOUT.
    if ((state_q == RELEASE || state_q == RUN) && !reset_o[0]) begin
      ctr_d = ctr_inc;
    end

    // Finishes count only from channels already out of reset.
    if (state_q == RELEASE || state_q == RUN) begin
      finished_d = finished_o | (finish_v_i & ~reset_o);
    end

    unique case (state_q)
      WAIT_TAG: begin
        if (all_tags) begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
        end
      end
      SETTLE: begin
        if (!all_tags) begin
          state_d = WAIT_TAG;
        end else if (settle_cnt_q == settle_last_lp) begin
          state_d   = RELEASE;
          rel_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 32'd1;
        end
      end
      RELEASE: begin
        for (int unsigned k = 0; k < num_channels_p; k++) begin
          if (rel_cnt_q == k * stagger_p) begin
            reset_d[k] = 1'b0;
          end
        end
        rel_cnt_d = rel_cnt_q + 32'd1;
        if (rel_cnt_q == release_last_lp) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Completion is checked first so it wins over a same-edge timeout.
        if (&finished_d) begin
          state_d    = DONE;
          all_done_d = 1'b1;
        end
`ifdef SPMD_TB_WATCHDOG_EN
        else if (ctr_d >= timeout_lim_lp) begin
          state_d   = TIMEOUT;
          timeout_d = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= WAIT_TAG;
      settle_cnt_q <= '0;
      rel_cnt_q    <= '0;
      reset_o      <= '1;
      finished_o   <= '0;
      all_done_o   <= 1'b0;
      global_ctr_o <= '0;
`ifdef SPMD_TB_WATCHDOG_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      rel_cnt_q    <= rel_cnt_d;
      reset_o      <= reset_d;
      finished_o   <= finished_d;
      all_done_o   <= all_done_d;
      global_ctr_o <= ctr_d;
`ifdef SPMD_TB_WATCHDOG_EN
      timeout_q    <= timeout_d;
`ifndef SYNTHESIS
      if (state_q == RUN && state_d == TIMEOUT) begin
        $display("spmd_tb_reset_sequencer: error, watchdog expired at cycle %0d", ctr_d);
      end
`endif
`endif
    end
  end

endmodule
